// File: rtl/bcd_updown_display_pkg.sv
// rtl/bcd_updown_display_pkg.sv - shared BCD types, 7-segment table and load clamp
package bcd_updown_display_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] BLANK = 8'hFF;

    // Active-low {dp, g..a}; codes 10-15 never show a glyph.
    localparam logic [15:0][7:0] SEG_TABLE = {
        BLANK, BLANK, BLANK, BLANK, BLANK, BLANK,
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic bcd_t bcd_clamp(input logic [3:0] nibble);
        return (nibble > 4'd9) ? 4'd9 : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - single BCD nibble up/down step with wrap-out
module bcd_digit_cell
    import bcd_updown_display_pkg::*;
(
    input  bcd_t value,
    input  logic up,
    input  logic step,
    output bcd_t next_value,
    output logic wrap
);

    always_comb begin
        next_value = value;
        wrap       = 1'b0;
        if (step) begin
            if (up) begin
                if (value >= 4'd9) begin
                    next_value = 4'd0;
                    wrap       = 1'b1;
                end else begin
                    next_value = value + 4'd1;
                end
            end else begin
                if (value == 4'd0) begin
                    next_value = 4'd9;
                    wrap       = 1'b1;
                end else begin
                    next_value = value - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updown_display.sv
// rtl/bcd_updown_display.sv - prescaled BCD up/down counter with multiplexed 7-segment scan
module bcd_updown_display
    import bcd_updown_display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int SCAN_HZ  = 1000,
    parameter int SATURATE = 0
) (
    input  logic                  clk_50MHz,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  updown,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  blank_lz,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     digit
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    // Assertion is immediate; dividers only start two clocks after release.
    logic [1:0] rst_sync;
    logic       run;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign run = rst_sync[1];

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = run && (presc == TICK_LAST);

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset)   presc <= '0;
        else if (run) presc <= tick ? '0 : presc + 1'b1;
    end

    logic [DIGITS:0]       carry;
    logic [4*DIGITS-1:0]   stepped;
    logic [4*DIGITS-1:0]   loaded;
    logic                  boundary;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_cell
        bcd_digit_cell u_cell (
            .value      (count[4*i +: 4]),
            .up         (updown),
            .step       (carry[i]),
            .next_value (stepped[4*i +: 4]),
            .wrap       (carry[i+1])
        );
        assign loaded[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
    end

    // A wrap-out from the top cell means every digit sat at its limit.
    assign boundary = carry[DIGITS];

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                count <= loaded;
            end else if (tick && en) begin
                tc <= boundary;
                if (!(boundary && (SATURATE != 0))) count <= stepped;
            end
        end
    end

    logic [SW-1:0] sdiv;
    logic [IW-1:0] idx;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            sdiv <= '0;
            idx  <= '0;
        end else if (run) begin
            if (sdiv == SCAN_LAST) begin
                sdiv <= '0;
                idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                sdiv <= sdiv + 1'b1;
            end
        end
    end

    // lead_zero[k]: digit k and everything above it are zero.
    logic [DIGITS-1:0] lead_zero;

    always_comb begin
        lead_zero = '0;
        lead_zero[DIGITS-1] = (count[4*DIGITS-1 -: 4] == 4'd0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            lead_zero[k] = lead_zero[k+1] && (count[4*k +: 4] == 4'd0);
        end
    end

    bcd_t cur;
    logic blank_now;

    assign cur       = count[4*idx +: 4];
    assign blank_now = blank_lz && (idx != '0) && lead_zero[idx];

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            digit <= ~DIGITS'(1);
            seg   <= SEG_TABLE[4'd0];
        end else begin
            digit <= ~(DIGITS'(1) << idx);
            seg   <= blank_now ? BLANK : SEG_TABLE[cur];
        end
    end

endmodule

// File: tb/tb_bcd_updown_display.sv
// tb/tb_bcd_updown_display.sv - scoreboard bench for bcd_updown_display (wrap and saturate)
module tb_bcd_updown_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en, updown, load, blank_lz;
    logic [15:0] load_val;
    logic [15:0] count_m, count_s;
    logic        tc_m, tc_s;
    logic [7:0]  seg_m, seg_s;
    logic [3:0]  digit_m, digit_s;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit scan_on = 1'b0;

    logic [16:0] q_m[$];
    logic [16:0] q_s[$];
    logic [16:0] q_scan[$];
    logic [15:0] prev_m = '0;
    logic [15:0] prev_s = '0;
    logic [3:0]  prev_d = 4'b1110;

    always #5 clk = ~clk;

    bcd_updown_display #(.DIGITS(4), .CLK_HZ(20), .TICK_HZ(2), .SCAN_HZ(1), .SATURATE(0)) dut_m (
        .clk_50MHz(clk), .reset(reset), .en(en), .updown(updown), .load(load),
        .load_val(load_val), .blank_lz(blank_lz), .count(count_m), .tc(tc_m),
        .seg(seg_m), .digit(digit_m)
    );

    bcd_updown_display #(.DIGITS(4), .CLK_HZ(20), .TICK_HZ(2), .SCAN_HZ(1), .SATURATE(1)) dut_s (
        .clk_50MHz(clk), .reset(reset), .en(en), .updown(updown), .load(load),
        .load_val(load_val), .blank_lz(blank_lz), .count(count_s), .tc(tc_s),
        .seg(seg_s), .digit(digit_s)
    );

    // Clocks since the last reset release; count steps land on cyc%10==2, anode changes on cyc%5==3.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h, want no event (t=%0t)", name, act, $time);
    endtask

    always @(negedge clk) begin
        if (count_m !== prev_m || tc_m === 1'b1) begin
            if (q_m.size() == 0) fail("wrap_unexpected_event", {15'd0, tc_m, count_m});
            else begin
                check("wrap_count", count_m, q_m[0][15:0]);
                check("wrap_tc", tc_m, q_m[0][16]);
                void'(q_m.pop_front());
            end
        end
        prev_m <= count_m;
    end

    always @(negedge clk) begin
        if (count_s !== prev_s || tc_s === 1'b1) begin
            if (q_s.size() == 0) fail("sat_unexpected_event", {15'd0, tc_s, count_s});
            else begin
                check("sat_count", count_s, q_s[0][15:0]);
                check("sat_tc", tc_s, q_s[0][16]);
                void'(q_s.pop_front());
            end
        end
        prev_s <= count_s;
    end

    always @(negedge clk) begin
        if (scan_on && digit_m !== prev_d) begin
            if (q_scan.size() == 0) fail("scan_unexpected", {28'd0, digit_m});
            else begin
                check("scan_phase", cyc % 20, {27'd0, q_scan[0][16:12]});
                check("scan_digit", digit_m, q_scan[0][11:8]);
                check("scan_seg", seg_m, q_scan[0][7:0]);
                void'(q_scan.pop_front());
            end
        end
        prev_d <= digit_m;
    end

    task automatic push_both(input logic [15:0] c, input logic t_wrap, input logic t_sat);
        q_m.push_back({t_wrap, c});
        q_s.push_back({t_sat, c});
    endtask

    task automatic do_load(input logic [15:0] v);
        @(posedge clk); #1;
        load = 1'b1;
        load_val = v;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Twenty enabled cycles always contain exactly two ticks.
    task automatic en_window(input logic dir);
        @(posedge clk); #1;
        updown = dir;
        en = 1'b1;
        repeat (20) @(posedge clk);
        #1 en = 1'b0;
    endtask

    task automatic wait_phase(input int modulo, input int p);
        bit hit = 1'b0;
        for (int k = 0; k < 2 * modulo + 2 && !hit; k++) begin
            @(posedge clk); #1;
            if (cyc % modulo == p) hit = 1'b1;
        end
        if (!hit) fail("phase_timeout", cyc);
    endtask

    task automatic scan_round(input logic bl, input logic [31:0] segs);
        blank_lz = bl;
        wait_phase(20, 19);
        scan_on = 1'b1;
        q_scan.push_back({5'd3,  4'b1110, segs[7:0]});
        q_scan.push_back({5'd8,  4'b1101, segs[15:8]});
        q_scan.push_back({5'd13, 4'b1011, segs[23:16]});
        q_scan.push_back({5'd18, 4'b0111, segs[31:24]});
        for (int k = 0; k < 40 && q_scan.size() != 0; k++) @(negedge clk);
        check("scan_drained", q_scan.size(), 0);
        scan_on = 1'b0;
        q_scan.delete();
    endtask

    initial begin
        en = 1'b0; updown = 1'b1; load = 1'b0; load_val = '0; blank_lz = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count", count_m, 16'h0000);
        check("rst_tc", tc_m, 1'b0);
        check("rst_digit", digit_m, 4'b1110);
        check("rst_seg", seg_m, 8'hC0);

        push_both(16'h0001, 0, 0);
        push_both(16'h0002, 0, 0);
        push_both(16'h0003, 0, 0);
        en = 1'b1; updown = 1'b1;
        reset = 1'b1;
        repeat (31) @(posedge clk);
        @(negedge clk);
        check("tick_c31", count_m, 16'h0002);
        @(negedge clk);
        check("tick_c32", count_m, 16'h0003);
        en = 1'b0;

        push_both(16'h9998, 0, 0);
        push_both(16'h9999, 0, 0);
        q_m.push_back({1'b1, 16'h0000});
        q_s.push_back({1'b1, 16'h9999});
        do_load(16'h9998);
        en_window(1'b1);

        push_both(16'h0001, 0, 0);
        push_both(16'h0000, 0, 0);
        q_m.push_back({1'b1, 16'h9999});
        q_s.push_back({1'b1, 16'h0000});
        do_load(16'h0001);
        en_window(1'b0);
        push_both(16'h0099, 0, 0);
        do_load(16'h00AF);

        push_both(16'h1234, 0, 0);
        wait_phase(10, 1);
        load = 1'b1; load_val = 16'h1234; en = 1'b1; updown = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; en = 1'b0;
        check("load_vs_tick_count", count_m, 16'h1234);
        check("load_vs_tick_tc", tc_m, 1'b0);
        check("load_vs_tick_sat", count_s, 16'h1234);

        // A load mid-interval must leave the tick phase alone.
        push_both(16'h1240, 0, 0);
        push_both(16'h1241, 0, 0);
        wait_phase(10, 5);
        load = 1'b1; load_val = 16'h1240;
        @(posedge clk); #1;
        load = 1'b0;
        en = 1'b1; updown = 1'b1;
        wait_phase(10, 1);
        check("phase_kept_pre", count_m, 16'h1240);
        @(posedge clk); #1;
        check("phase_kept_post", count_m, 16'h1241);
        en = 1'b0;

        push_both(16'h0050, 0, 0);
        do_load(16'h0050);
        scan_round(1'b1, {8'hFF, 8'hFF, 8'h92, 8'hC0});
        scan_round(1'b0, {8'hC0, 8'hC0, 8'h92, 8'hC0});
        push_both(16'h0000, 0, 0);
        do_load(16'h0000);
        scan_round(1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0});
        push_both(16'h0427, 0, 0);
        do_load(16'h0427);
        scan_round(1'b1, {8'hFF, 8'h99, 8'hA4, 8'hF8});

        push_both(16'h0000, 0, 0);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("async_rst_count", count_m, 16'h0000);
        check("async_rst_tc", tc_m, 1'b0);
        check("async_rst_digit", digit_m, 4'b1110);
        check("async_rst_seg", seg_m, 8'hC0);
        repeat (3) @(negedge clk);

        push_both(16'h0001, 0, 0);
        en = 1'b1; updown = 1'b1;
        reset = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        check("resync_c11", count_m, 16'h0000);
        @(negedge clk);
        check("resync_c12", count_m, 16'h0001);
        en = 1'b0;

        repeat (30) @(negedge clk);
        check("wrap_queue_empty", q_m.size(), 0);
        check("sat_queue_empty", q_s.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_updown_display.md
BCD_UPDOWN_DISPLAY -- requirements
Module: bcd_updown_display

Interface
REQ-001 The block SHALL provide parameter DIGITS, default 4, meaning the number of BCD digits counted and displayed (range 1..8).
REQ-002 The block SHALL provide parameter CLK_HZ, default 50_000_000, meaning the input clock frequency.
REQ-003 The block SHALL provide parameter TICK_HZ, default 1, meaning the count-step rate.
REQ-004 The block SHALL provide parameter SCAN_HZ, default 1000, meaning the full-display refresh rate.
REQ-005 The block SHALL provide parameter SATURATE, default 0, where 0 selects wrap and 1 selects hold-at-limit.
REQ-006 The block SHALL provide port clk_50MHz, input, 1 bit, the single clock.
REQ-007 The block SHALL provide port reset, input, 1 bit, an asynchronous active-low reset.
REQ-008 The block SHALL provide port en, input, 1 bit, count enable.
REQ-009 The block SHALL provide port updown, input, 1 bit, where 1 counts up and 0 counts down.
REQ-010 The block SHALL provide port load, input, 1 bit, a synchronous load strobe.
REQ-011 The block SHALL provide port load_val, input, 4*DIGITS bits, the BCD load value.
REQ-012 The block SHALL provide port blank_lz, input, 1 bit, enabling leading-zero blanking.
REQ-013 The block SHALL provide port count, output, 4*DIGITS bits, the registered BCD count.
REQ-014 The block SHALL provide port tc, output, 1 bit, a one-cycle terminal-count pulse.
REQ-015 The block SHALL provide port seg, output, 8 bits, active-low segments, where seg[7] is dp (always 1), seg[6:0] is g..a.
REQ-016 The block SHALL provide port digit, output, DIGITS bits, active-low one-hot anodes.

Function
REQ-017 Prescaler: counts 0..CLK_HZ/TICK_HZ-1; an internal tick SHALL be asserted for exactly one cycle at the terminal value, then the prescaler returns to 0.
REQ-018 Count SHALL update in the cycle after a tick only if en=1, moving by exactly one in the direction of updown sampled on the tick cycle.
REQ-019 Counting SHALL be decimal: each nibble 0..9, carry/borrow ripples across all digits in the same cycle.
REQ-020 Up at all-9s: SATURATE=0 -> all-0s; SATURATE=1 -> hold all-9s.
REQ-021 Down at all-0s: SATURATE=0 -> all-9s; SATURATE=1 -> hold all-0s.
REQ-022 tc SHALL pulse high for one cycle, on the same edge as the count update, whenever a boundary step (REQ-020/021) occurs in either mode.
REQ-023 load=1 SHALL set count to load_val on the next edge regardless of tick/en, and SHALL take priority over a coincident tick (that tick is discarded, tc=0).
REQ-024 Any load_val nibble >9 SHALL be loaded as 9.
REQ-025 load SHALL NOT reset the prescaler.
REQ-026 Scan: a refresh divider of CLK_HZ/(SCAN_HZ*DIGITS) cycles SHALL advance the digit index 0..DIGITS-1, wrapping; index 0 is the least significant digit.
REQ-027 digit SHALL drive low only the bit of the current index; seg SHALL show the 7-seg pattern of that nibble, registered together with digit (same cycle, no skew).
REQ-028 If blank_lz=1, a digit SHALL be blanked (seg=8'hFF, anode still driven) when it and all more-significant digits are 0, with digit 0 never blanked.
REQ-029 Changes to updown/en between ticks SHALL have no effect on count.

Reset
REQ-030 reset=0 SHALL asynchronously clear the prescaler, scan divider and scan index, set count=0 and tc=0, set digit to all-1s except bit 0 low, and set seg=8'hC0 (pattern "0").
REQ-031 Release SHALL be synchronised internally (two-flop) so that the first tick occurs exactly CLK_HZ/TICK_HZ cycles after the synchronised release.
REQ-032 Reset mid-count SHALL discard any pending tick and tc.

Structure
REQ-033 A shared package SHALL hold the 16-entry 7-seg pattern constant table (0-9, blank), the BLANK constant, and a BCD nibble typedef.
REQ-034 One sub-module, bcd_digit_cell (single-nibble up/down with carry-in/carry-out), SHALL be instantiated DIGITS times in a generate loop.
REQ-035 Dividers SHALL be sized with $clog2 of their terminal values.

Verification (CLK_HZ=20, TICK_HZ=2, SCAN_HZ=1, DIGITS=4 unless stated)
REQ-036 Reset, then en=1, updown=1 for 30 cycles -> count 0000->0001->0002->0003 with ticks on cycles 10, 20 and 30, tc=0.
REQ-037 load 0x9998, en=1, up, SATURATE=0 -> 9999, then 0000 with tc high for one cycle; with SATURATE=1 -> 9999 held, tc pulses on each tick.
REQ-038 load 0x0001, down -> 0000, then 9999 (wrap) with tc pulse; load_val 0x00AF -> count 0x0099.
REQ-039 load asserted on the same cycle as a tick with load_val 0x1234 -> count 0x1234, no increment, tc=0.
REQ-040 count 0x0050, blank_lz=1 -> digits 3 and 2 seg=FF, digit 1 shows 5 (seg=0x92), digit 0 shows 0 (seg=0xC0); anodes cycle 1110,1101,1011,0111 every 5 cycles.
REQ-041 reset asserted mid-count at 0x0427 -> count, tc, seg and digit take their reset values immediately without waiting for a clock edge.
